counter_seek_ctrl: RTL and testbench

- Initiator side of the up/down counter control interface: drives load/up_down/enable/d_in of a WIDTH-bit counter so that it reaches a requested target value.
- Reads back the counter's count as feedback and reports completion and match status.
- Sits between a command source (start/target handshake) and an updown counter instance.

---
 rtl/counter_seek_ctrl_if.sv | 33 +++
 rtl/counter_seek_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_counter_seek_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/counter_seek_ctrl_if.sv
// -----------------------------------------------------------------------------
// counter_seek_ctrl_if
// Command handshake between a command source and counter_seek_ctrl.
//   start  : command request, accepted when start && ready at a clk edge
//   jump   : 1 = load target directly, 0 = step the counter to target
//   target : requested counter value
//   ready  : controller idle and able to accept a command
//   busy   : controller executing a command
//   done   : one-cycle completion pulse
//   match  : valid with done, counter equalled target at check time
// Modports: master = command source, slave = counter_seek_ctrl.
// -----------------------------------------------------------------------------
interface counter_seek_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             jump;
    logic [WIDTH-1:0] target;
    logic             ready;
    logic             busy;
    logic             done;
    logic             match;

    modport master (
        output start, jump, target,
        input  ready, busy, done, match
    );

    modport slave (
        input  start, jump, target,
        output ready, busy, done, match
    );
endinterface

// File: rtl/counter_seek_ctrl.sv
// -----------------------------------------------------------------------------
// counter_seek_ctrl
// Drives the load/up_down/enable/d_in controls of a WIDTH-bit up/down counter
// so that it reaches a requested target, either by a direct load (jump) or by
// counting along the shorter way around the modulo-2^WIDTH ring, then checks
// the counter's count against the target and reports done/match.
//
// Ports:
//   clk          : rising-edge clock, shared with the driven counter
//   rst          : synchronous active-high reset
//   cmd          : command handshake (slave modport of counter_seek_ctrl_if)
//   cnt_load     : counter load strobe
//   cnt_up_down  : counter direction, 1 = up, 0 = down
//   cnt_enable   : counter count enable
//   cnt_d        : counter load value
//   count_in     : counter count feedback
//   abort        : (COUNTER_SEEK_ABORT_EN only) cancel a LOAD/STEP in progress
//
// Optional feature: define COUNTER_SEEK_ABORT_EN to add the abort input.
// All outputs are registered.
// -----------------------------------------------------------------------------
module counter_seek_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    counter_seek_ctrl_if.slave cmd,
    output logic               cnt_load,
    output logic               cnt_up_down,
    output logic               cnt_enable,
    output logic [WIDTH-1:0]   cnt_d,
`ifdef COUNTER_SEEK_ABORT_EN
    input  logic               abort,
`endif
    input  logic [WIDTH-1:0]   count_in
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_STEP  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             load_q, load_d;
    logic             up_down_q, up_down_d;
    logic             enable_q, enable_d;
    logic [WIDTH-1:0] cnt_d_q, cnt_d_d;
    logic             done_q, done_d;
    logic             match_q, match_d;

    // Modular distances both ways round the ring; the shorter one never
    // exceeds 2^(WIDTH-1), so it fits in WIDTH bits.
    logic [WIDTH-1:0] up_dist;
    logic [WIDTH-1:0] dn_dist;
    logic             go_up;
    logic [WIDTH-1:0] step_dist;

    assign up_dist   = cmd.target - count_in;
    assign dn_dist   = count_in - cmd.target;
    assign go_up     = (up_dist <= dn_dist);   // a tie goes up
    assign step_dist = go_up ? up_dist : dn_dist;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        target_d    = target_q;
        remaining_d = remaining_q;
        up_down_d   = up_down_q;
        cnt_d_d     = cnt_d_q;
        match_d     = match_q;
        load_d      = 1'b0;
        enable_d    = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd.start && ready_q) begin
                    target_d = cmd.target;
                    if (cmd.jump) begin
                        state_d = S_LOAD;
                        load_d  = 1'b1;
                        cnt_d_d = cmd.target;
                    end else begin
                        up_down_d   = go_up;
                        remaining_d = step_dist;
                        if (step_dist == '0) begin
                            state_d = S_CHECK;
                        end else begin
                            state_d  = S_STEP;
                            enable_d = 1'b1;
                        end
                    end
                end
            end
            S_LOAD: begin
                state_d = S_CHECK;
            end
            S_STEP: begin
                // enable is registered, so it must drop on the edge that
                // consumes the last count to avoid an extra step.
                remaining_d = remaining_q - ONE;
                if (remaining_q == ONE) begin
                    state_d = S_CHECK;
                end else begin
                    enable_d = 1'b1;
                end
            end
            S_CHECK: begin
                match_d = (count_in == target_q);
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef COUNTER_SEEK_ABORT_EN
        if (abort && (state_q == S_LOAD || state_q == S_STEP)) begin
            state_d     = S_DONE;
            remaining_d = '0;
            load_d      = 1'b0;
            enable_d    = 1'b0;
            done_d      = 1'b1;
            match_d     = 1'b0;
        end
`endif

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            target_q    <= '0;
            remaining_q <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            load_q      <= 1'b0;
            up_down_q   <= 1'b1;
            enable_q    <= 1'b0;
            cnt_d_q     <= '0;
            done_q      <= 1'b0;
            match_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            remaining_q <= remaining_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            load_q      <= load_d;
            up_down_q   <= up_down_d;
            enable_q    <= enable_d;
            cnt_d_q     <= cnt_d_d;
            done_q      <= done_d;
            match_q     <= match_d;
        end
    end

    assign cmd.ready   = ready_q;
    assign cmd.busy    = busy_q;
    assign cmd.done    = done_q;
    assign cmd.match   = match_q;
    assign cnt_load    = load_q;
    assign cnt_up_down = up_down_q;
    assign cnt_enable  = enable_q;
    assign cnt_d       = cnt_d_q;

endmodule

// File: tb/tb_counter_seek_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_seek_ctrl
// Directed bench for counter_seek_ctrl with a behavioural up/down counter
// closing the feedback loop. Inputs change and outputs are sampled 1 ns after
// the rising edge. Define COUNTER_SEEK_ABORT_EN to include the abort scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_counter_seek_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cnt_rst;
    logic       cnt_load;
    logic       cnt_up_down;
    logic       cnt_enable;
    logic [3:0] cnt_d;
    logic [3:0] count;
`ifdef COUNTER_SEEK_ABORT_EN
    logic       abort = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    counter_seek_ctrl_if #(.WIDTH(4)) cmd_if ();

    counter_seek_ctrl #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (cmd_if),
        .cnt_load    (cnt_load),
        .cnt_up_down (cnt_up_down),
        .cnt_enable  (cnt_enable),
        .cnt_d       (cnt_d),
`ifdef COUNTER_SEEK_ABORT_EN
        .abort       (abort),
`endif
        .count_in    (count)
    );

    always #5 clk = ~clk;

    // Driven counter; it has its own reset so a controller reset leaves it.
    always @(posedge clk) begin
        if (cnt_rst)          count <= 4'd0;
        else if (cnt_load)    count <= cnt_d;
        else if (cnt_enable)  count <= cnt_up_down ? count + 4'd1 : count - 4'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one command and watches until done (bounded). lat is the cycle
    // index after the accepting edge at which done is seen (1 = next cycle).
    task automatic run_cmd(input logic j, input logic [3:0] tgt, input bit hold,
                           output int lat, output int ens, output int loads,
                           output logic [3:0] ld_val, output bit up_seen,
                           output bit dn_seen, output bit overlap, output logic mtch);
        lat = -1; ens = 0; loads = 0; ld_val = 4'hx;
        up_seen = 0; dn_seen = 0; overlap = 0; mtch = 1'bx;
        cmd_if.start  = 1'b1;
        cmd_if.jump   = j;
        cmd_if.target = tgt;
        tick();
        if (hold) begin
            cmd_if.jump   = 1'b1;
            cmd_if.target = 4'hF;
        end else begin
            cmd_if.start = 1'b0;
        end
        for (int n = 1; n <= 40; n++) begin
            if (cnt_load) begin loads++; ld_val = cnt_d; end
            if (cnt_enable) begin
                ens++;
                if (cnt_up_down) up_seen = 1; else dn_seen = 1;
            end
            if (cnt_load && cnt_enable) overlap = 1;
            if (cmd_if.done) begin lat = n; mtch = cmd_if.match; break; end
            tick();
        end
        cmd_if.start = 1'b0;
        checks++;
        if (lat < 0) begin
            failures++;
            $display("FAIL cmd_timeout target=%h got no done within 40 cycles, required done", tgt);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; cnt_rst = 1'b1;
        cmd_if.start = 1'b0; cmd_if.jump = 1'b0; cmd_if.target = 4'h0;
        tick(); tick();
        rst = 1'b0; cnt_rst = 1'b0;
        checks++; if (cmd_if.ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", cmd_if.ready); end
        checks++; if (cmd_if.busy !== 1'b0)  begin failures++; $display("FAIL rst_busy got=%b exp=0", cmd_if.busy); end
        checks++; if (cnt_load !== 1'b0)     begin failures++; $display("FAIL rst_load got=%b exp=0", cnt_load); end
        checks++; if (cnt_up_down !== 1'b1)  begin failures++; $display("FAIL rst_up_down got=%b exp=1", cnt_up_down); end
        checks++; if (cnt_enable !== 1'b0)   begin failures++; $display("FAIL rst_enable got=%b exp=0", cnt_enable); end
        checks++; if (cnt_d !== 4'h0)        begin failures++; $display("FAIL rst_cnt_d got=%h exp=0", cnt_d); end
        checks++; if (cmd_if.done !== 1'b0)  begin failures++; $display("FAIL rst_done got=%b exp=0", cmd_if.done); end
        checks++; if (cmd_if.match !== 1'b0) begin failures++; $display("FAIL rst_match got=%b exp=0", cmd_if.match); end
    endtask

    task automatic test_jump();
        int lat, ens, loads; logic [3:0] ldv; bit up, dn, ov; logic m;
        run_cmd(1'b1, 4'h7, 1'b0, lat, ens, loads, ldv, up, dn, ov, m);
        checks++; if (lat !== 3)     begin failures++; $display("FAIL jump_latency got=%0d exp=3", lat); end
        checks++; if (loads !== 1)   begin failures++; $display("FAIL jump_load_pulses got=%0d exp=1", loads); end
        checks++; if (ldv !== 4'h7)  begin failures++; $display("FAIL jump_cnt_d got=%h exp=7", ldv); end
        checks++; if (ens !== 0)     begin failures++; $display("FAIL jump_enables got=%0d exp=0", ens); end
        checks++; if (m !== 1'b1)    begin failures++; $display("FAIL jump_match got=%b exp=1", m); end
        checks++; if (count !== 4'h7) begin failures++; $display("FAIL jump_count got=%h exp=7", count); end
        checks++; if (cmd_if.ready !== 1'b1) begin failures++; $display("FAIL jump_ready_after got=%b exp=1", cmd_if.ready); end
    endtask

    // Step command with expected enable count, direction and final count.
    task automatic test_step(input string name, input logic [3:0] tgt,
                             input int exp_ens, input bit exp_up);
        int lat, ens, loads; logic [3:0] ldv; bit up, dn, ov; logic m;
        run_cmd(1'b0, tgt, 1'b0, lat, ens, loads, ldv, up, dn, ov, m);
        checks++; if (lat !== exp_ens + 2) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_ens + 2); end
        checks++; if (ens !== exp_ens) begin failures++; $display("FAIL %s_enables got=%0d exp=%0d", name, ens, exp_ens); end
        if (exp_ens > 0) begin
            checks++;
            if (up !== exp_up || dn !== !exp_up) begin
                failures++; $display("FAIL %s_direction got up=%0d dn=%0d exp up=%0d", name, up, dn, exp_up);
            end
        end
        checks++; if (loads !== 0)  begin failures++; $display("FAIL %s_loads got=%0d exp=0", name, loads); end
        checks++; if (ov !== 1'b0)  begin failures++; $display("FAIL %s_load_enable_overlap got=1 exp=0", name); end
        checks++; if (m !== 1'b1)   begin failures++; $display("FAIL %s_match got=%b exp=1", name, m); end
        checks++; if (count !== tgt) begin failures++; $display("FAIL %s_count got=%h exp=%h", name, count, tgt); end
    endtask

    task automatic jump_to(input logic [3:0] tgt);
        int lat, ens, loads; logic [3:0] ldv; bit up, dn, ov; logic m;
        run_cmd(1'b1, tgt, 1'b0, lat, ens, loads, ldv, up, dn, ov, m);
        checks++; if (count !== tgt) begin failures++; $display("FAIL jump_to_count got=%h exp=%h", count, tgt); end
    endtask

    task automatic test_reset_mid_step();
        bit saw_done = 0;
        jump_to(4'h0);
        cmd_if.start = 1'b1; cmd_if.jump = 1'b0; cmd_if.target = 4'h5;
        tick();
        cmd_if.start = 1'b0;
        checks++; if (cnt_enable !== 1'b1) begin failures++; $display("FAIL midrst_enable_before got=%b exp=1", cnt_enable); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (cmd_if.ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", cmd_if.ready); end
        checks++; if (cmd_if.busy !== 1'b0)  begin failures++; $display("FAIL midrst_busy got=%b exp=0", cmd_if.busy); end
        checks++; if (cnt_enable !== 1'b0)   begin failures++; $display("FAIL midrst_enable got=%b exp=0", cnt_enable); end
        for (int i = 0; i < 5; i++) begin
            if (cmd_if.done) saw_done = 1;
            tick();
        end
        checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL midrst_done_pulse got=1 exp=0"); end
        checks++; if (count !== 4'h2)    begin failures++; $display("FAIL midrst_count got=%h exp=2", count); end
    endtask

    task automatic test_start_while_busy();
        int lat, ens, loads; logic [3:0] ldv; bit up, dn, ov; logic m;
        // From 2, step up to 4 while start stays high with a jump-to-F command.
        run_cmd(1'b0, 4'h4, 1'b1, lat, ens, loads, ldv, up, dn, ov, m);
        checks++; if (lat !== 4)      begin failures++; $display("FAIL busy_latency got=%0d exp=4", lat); end
        checks++; if (ens !== 2)      begin failures++; $display("FAIL busy_enables got=%0d exp=2", ens); end
        checks++; if (loads !== 0)    begin failures++; $display("FAIL busy_loads got=%0d exp=0", loads); end
        tick();
        checks++; if (cmd_if.ready !== 1'b1 || cnt_load !== 1'b0) begin
            failures++; $display("FAIL busy_idle_after got ready=%b load=%b exp ready=1 load=0", cmd_if.ready, cnt_load);
        end
        checks++; if (count !== 4'h4) begin failures++; $display("FAIL busy_count got=%h exp=4", count); end
    endtask

`ifdef COUNTER_SEEK_ABORT_EN
    task automatic test_abort();
        jump_to(4'h0);
        cmd_if.start = 1'b1; cmd_if.jump = 1'b0; cmd_if.target = 4'h6;
        tick();
        cmd_if.start = 1'b0;
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (cnt_enable !== 1'b0)   begin failures++; $display("FAIL abort_enable got=%b exp=0", cnt_enable); end
        checks++; if (cmd_if.done !== 1'b1)  begin failures++; $display("FAIL abort_done got=%b exp=1", cmd_if.done); end
        checks++; if (cmd_if.match !== 1'b0) begin failures++; $display("FAIL abort_match got=%b exp=0", cmd_if.match); end
        checks++; if (count !== 4'h3)        begin failures++; $display("FAIL abort_count got=%h exp=3", count); end
        tick();
        checks++; if (cmd_if.ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", cmd_if.ready); end
    endtask
`endif

    initial begin
        test_reset();
        checks++; if (count !== 4'h0) begin failures++; $display("FAIL rst_count got=%h exp=0", count); end
        test_jump();
        test_step("step_up", 4'hB, 4, 1'b1);     // 7 -> B
        test_step("step_down", 4'h8, 3, 1'b0);   // B -> 8
        test_step("step_equal", 4'h8, 0, 1'b1);  // 8 -> 8
        jump_to(4'hE);
        test_step("step_wrap", 4'h1, 3, 1'b1);   // E -> F -> 0 -> 1
        jump_to(4'h0);
        test_step("step_tie", 4'h8, 8, 1'b1);    // 0 -> 8, tie goes up
        test_reset_mid_step();
        test_start_while_busy();
`ifdef COUNTER_SEEK_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
